segment_limit_unit: RTL and testbench

//  Pipelined, multi-channel segment limit checker for address generation.

---
 rtl/segment_limit_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_segment_limit_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_limit_unit.sv
// -----------------------------------------------------------------------------
// segment_limit_unit
//
// Two-stage pipelined segment limit checker for address generation. Each
// transaction carries NUM_CH independent accesses. Every access has a start
// address, a segment and a size code, and is checked against a programmable
// per-segment limit. The unit raises a per-channel exception and keeps a
// sticky record of the first fault that reaches the consumer.
//
// Ports
//   clk        : clock
//   reset      : synchronous, active-low reset
//   in_valid   : transaction offered
//   in_ready   : transaction accepted when in_valid & in_ready
//   addr       : NUM_CH start addresses, channel 0 in the LSBs
//   addr_vld   : per-channel "real access" flag
//   seg        : per-channel segment (0 ES, 1 CS, 2 SS, 3 DS, 4 FS, 5 GS,
//                6/7 reserved with a fixed limit of 0)
//   size       : per-channel size code (2=16b, 3=32b, 5=64b, other=8b/none)
//   lim_we     : limit register write strobe
//   lim_sel    : segment whose limit is written (6/7 ignored)
//   lim_wdata  : new limit value
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
//   exc        : per-channel limit exception
//   any_exc    : OR of exc
//   flt_valid  : sticky, a fault has been recorded
//   flt_addr   : start address of the first recorded fault
//   flt_seg    : segment of the first recorded fault
//   flt_clr    : clear the sticky fault record
// -----------------------------------------------------------------------------
module segment_limit_unit #(
    parameter int              NUM_CH      = 2,
    parameter int              AW          = 32,
    parameter logic [7:0]      EXEMPT_MASK = 8'b0000_0100,
    parameter logic [AW-1:0]   RST_ES      = 32'h03ff_0000,
    parameter logic [AW-1:0]   RST_CS      = 32'h4fff_0000,
    parameter logic [AW-1:0]   RST_SS      = 32'hf000_0000,
    parameter logic [AW-1:0]   RST_DS      = 32'h11ff_0000,
    parameter logic [AW-1:0]   RST_FS      = 32'h03ff_0000,
    parameter logic [AW-1:0]   RST_GS      = 32'h07ff_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_CH*AW-1:0] addr,
    input  logic [NUM_CH-1:0]    addr_vld,
    input  logic [NUM_CH*3-1:0]  seg,
    input  logic [NUM_CH*3-1:0]  size,
    input  logic                 lim_we,
    input  logic [2:0]           lim_sel,
    input  logic [AW-1:0]        lim_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_CH-1:0]    exc,
    output logic                 any_exc,
    output logic                 flt_valid,
    output logic [AW-1:0]        flt_addr,
    output logic [2:0]           flt_seg,
    input  logic                 flt_clr
);

    localparam int NSEG = 6;

    // Byte offset of the last byte touched by an access of the given size.
    function automatic logic [AW-1:0] size_offset(input logic [2:0] code);
        logic [AW-1:0] off;
        case (code)
            3'd2:    off = AW'(1);
            3'd3:    off = AW'(3);
            3'd5:    off = AW'(7);
            default: off = '0;
        endcase
        return off;
    endfunction

    // End address; a carry out of the top bit saturates to all-ones so a
    // wrapping access can never slip under a limit.
    function automatic logic [AW-1:0] sat_end(input logic [AW-1:0] base,
                                              input logic [AW-1:0] off);
        logic [AW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return sum[AW] ? '1 : sum[AW-1:0];
    endfunction

    // Limit registers for the six architectural segments. The two reserved
    // segments read as a constant 0 through the lookup table.
    logic [AW-1:0] lim_q   [NSEG];
    logic [AW-1:0] lim_tbl [8];

    always_comb begin
        for (int s = 0; s < 8; s++) begin
            lim_tbl[s] = '0;
        end
        for (int s = 0; s < NSEG; s++) begin
            lim_tbl[s] = lim_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lim_q[0] <= RST_ES;
            lim_q[1] <= RST_CS;
            lim_q[2] <= RST_SS;
            lim_q[3] <= RST_DS;
            lim_q[4] <= RST_FS;
            lim_q[5] <= RST_GS;
        end else begin
            for (int s = 0; s < NSEG; s++) begin
                if (lim_we && (lim_sel == 3'(s))) begin
                    lim_q[s] <= lim_wdata;
                end
            end
        end
    end

    // Handshake: stage 2 moves when its slot is empty or being drained;
    // stage 1 moves when empty or when stage 2 moves.
    logic vld_p1;
    logic adv_p1;
    logic adv_p2;

    assign adv_p2   = !out_valid || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // ---------------- stage 1: end address, limit snapshot ----------------
    logic [AW-1:0]     end_p1  [NUM_CH];
    logic [AW-1:0]     lim_p1  [NUM_CH];
    logic [AW-1:0]     addr_p1 [NUM_CH];
    logic [2:0]        seg_p1  [NUM_CH];
    logic [NUM_CH-1:0] av_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    // The limit is captured from the register before any same-edge write,
    // so a write and an access in the same cycle see the old value.
    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                end_p1[i]  <= sat_end(addr[i*AW +: AW], size_offset(size[i*3 +: 3]));
                lim_p1[i]  <= lim_tbl[seg[i*3 +: 3]];
                addr_p1[i] <= addr[i*AW +: AW];
                seg_p1[i]  <= seg[i*3 +: 3];
            end
            av_p1 <= addr_vld;
        end
    end

    // ---------------- stage 2: compare, result register ----------------
    logic [NUM_CH-1:0] exc_c;
    logic [AW-1:0]     fa_addr_c;
    logic [2:0]        fa_seg_c;
    logic [AW-1:0]     fa_addr_p2;
    logic [2:0]        fa_seg_p2;

    // end == limit faults: the limit is the first illegal byte address.
    always_comb begin
        exc_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            exc_c[i] = av_p1[i] && !EXEMPT_MASK[seg_p1[i]] && !(end_p1[i] < lim_p1[i]);
        end
    end

    // Lowest-index faulting channel wins: scan downward so the last hit is
    // the lowest channel.
    always_comb begin
        fa_addr_c = '0;
        fa_seg_c  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (exc_c[i]) begin
                fa_addr_c = addr_p1[i];
                fa_seg_c  = seg_p1[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            exc       <= '0;
            any_exc   <= 1'b0;
        end else if (adv_p2) begin
            out_valid <= vld_p1;
            exc       <= vld_p1 ? exc_c : '0;
            any_exc   <= vld_p1 && (|exc_c);
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p2) begin
            fa_addr_p2 <= fa_addr_c;
            fa_seg_p2  <= fa_seg_c;
        end
    end

    // ---------------- fault record: capture on delivery ----------------
    logic deliver_fault;

    assign deliver_fault = out_valid && out_ready && any_exc;

    // A clear coinciding with a faulting delivery leaves the new fault
    // recorded: clear first, then capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flt_valid <= 1'b0;
            flt_addr  <= '0;
            flt_seg   <= '0;
        end else begin
            if (flt_clr) begin
                flt_valid <= 1'b0;
            end
            if (deliver_fault && (!flt_valid || flt_clr)) begin
                flt_valid <= 1'b1;
                flt_addr  <= fa_addr_p2;
                flt_seg   <= fa_seg_p2;
            end
        end
    end

endmodule

// File: tb/tb_segment_limit_unit.sv
// -----------------------------------------------------------------------------
// tb_segment_limit_unit
//
// Directed bench for segment_limit_unit (NUM_CH=2, AW=32). A queue-based
// model predicts every delivered result and the sticky fault record from the
// limit rules directly; directed transactions add literal expectations.
// Inputs change 1 time unit after the rising edge; everything is sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_segment_limit_unit;

    localparam int NUM_CH = 2;
    localparam int AW     = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   addr;
    logic [1:0]    addr_vld;
    logic [5:0]    seg;
    logic [5:0]    size;
    logic          lim_we;
    logic [2:0]    lim_sel;
    logic [31:0]   lim_wdata;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    exc;
    logic          any_exc;
    logic          flt_valid;
    logic [31:0]   flt_addr;
    logic [2:0]    flt_seg;
    logic          flt_clr;

    segment_limit_unit #(.NUM_CH(NUM_CH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr      (addr),
        .addr_vld  (addr_vld),
        .seg       (seg),
        .size      (size),
        .lim_we    (lim_we),
        .lim_sel   (lim_sel),
        .lim_wdata (lim_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exc       (exc),
        .any_exc   (any_exc),
        .flt_valid (flt_valid),
        .flt_addr  (flt_addr),
        .flt_seg   (flt_seg),
        .flt_clr   (flt_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [1:0]  exc;
        logic [31:0] fa;
        logic [2:0]  fs;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_lim [8];
    logic        m_flt_valid;
    logic [31:0] m_flt_addr;
    logic [2:0]  m_flt_seg;
    bit          chk_en     = 0;
    bit          prev_stall = 0;
    logic [1:0]  prev_exc;
    int          n_deliv    = 0;

    function automatic void model_reset();
        m_lim[0] = 32'h03ff_0000;
        m_lim[1] = 32'h4fff_0000;
        m_lim[2] = 32'hf000_0000;
        m_lim[3] = 32'h11ff_0000;
        m_lim[4] = 32'h03ff_0000;
        m_lim[5] = 32'h07ff_0000;
        m_lim[6] = 32'h0;
        m_lim[7] = 32'h0;
        m_flt_valid = 1'b0;
        m_flt_addr  = 32'h0;
        m_flt_seg   = 3'd0;
        q.delete();
    endfunction

    function automatic ent_t predict(input logic [63:0] a, input logic [1:0] v,
                                     input logic [5:0] s, input logic [5:0] z);
        ent_t e;
        bit   found = 0;
        e.exc = 2'b00;
        e.fa  = 32'h0;
        e.fs  = 3'd0;
        for (int ch = 0; ch < 2; ch++) begin
            logic [31:0]     ai;
            logic [2:0]      si;
            logic [2:0]      zi;
            longint unsigned last;
            longint unsigned off;
            ai = a[ch*32 +: 32];
            si = s[ch*3 +: 3];
            zi = z[ch*3 +: 3];
            off = (zi == 3'd2) ? 1 : (zi == 3'd3) ? 3 : (zi == 3'd5) ? 7 : 0;
            last = longint'(ai) + off;
            if (last > 64'hffff_ffff) last = 64'hffff_ffff;
            if (v[ch] && si != 3'd2 && !(last < longint'(m_lim[si]))) begin
                e.exc[ch] = 1'b1;
                if (!found) begin
                    found = 1;
                    e.fa  = ai;
                    e.fs  = si;
                end
            end
        end
        return e;
    endfunction

    // Single compare process: check what the last edge produced, then
    // advance the model by what the coming edge will do.
    always @(negedge clk) begin
        ent_t e;
        if (chk_en) begin
            check("flt_valid", flt_valid, m_flt_valid);
            check("flt_addr", flt_addr, m_flt_addr);
            check("flt_seg", flt_seg, m_flt_seg);
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_exc", exc, prev_exc);
            end
            if (out_valid && q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL spurious_out: out_valid=1 with no accepted transaction pending");
            end else if (out_valid) begin
                check("out_exc", exc, q[0].exc);
                check("out_any_exc", any_exc, |q[0].exc);
            end
        end
        prev_stall = chk_en && reset && out_valid && !out_ready;
        prev_exc   = exc;
        if (!reset) begin
            model_reset();
            chk_en = 1;
        end else if (chk_en) begin
            if (flt_clr) m_flt_valid = 1'b0;
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                n_deliv++;
                if (|e.exc && !m_flt_valid) begin
                    m_flt_valid = 1'b1;
                    m_flt_addr  = e.fa;
                    m_flt_seg   = e.fs;
                end
            end
            if (in_valid && in_ready) q.push_back(predict(addr, addr_vld, seg, size));
            if (lim_we && lim_sel < 3'd6) m_lim[lim_sel] = lim_wdata;
        end
    end

    // One transaction through an idle pipeline with out_ready=1, optionally
    // with a limit write in the accept cycle and flt_clr in the delivery cycle.
    task automatic xact(input string nm, input logic [63:0] a, input logic [1:0] v,
                        input logic [5:0] s, input logic [5:0] z,
                        input logic we, input logic [2:0] ls, input logic [31:0] lw,
                        input logic clr, input logic [1:0] exp);
        @(posedge clk); #1;
        addr = a; addr_vld = v; seg = s; size = z; in_valid = 1'b1;
        lim_we = we; lim_sel = ls; lim_wdata = lw;
        @(negedge clk);
        check({nm, "_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; lim_we = 1'b0;
        @(negedge clk);
        check({nm, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        flt_clr = clr;
        @(negedge clk);
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_exc"}, exc, exp);
        @(posedge clk); #1;
        flt_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int acc_stall;
        int d0;
        reset = 1'b0; in_valid = 1'b0; addr = '0; addr_vld = '0; seg = '0; size = '0;
        lim_we = 1'b0; lim_sel = '0; lim_wdata = '0; out_ready = 1'b1; flt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_exc", exc, 0);
        check("rst_any_exc", any_exc, 0);
        check("rst_flt_valid", flt_valid, 0);
        check("rst_flt_addr", flt_addr, 0);
        check("rst_flt_seg", flt_seg, 0);
        check("rst_in_ready", in_ready, 1);

        // 1: DS limit boundary
        xact("t1_ds_over", {32'h0, 32'h11fe_ffff}, 2'b01, {3'd0, 3'd3}, {3'd0, 3'd5},
             1'b0, 3'd0, 32'h0, 1'b0, 2'b01);
        check("t1_flt_valid", flt_valid, 1);
        check("t1_flt_addr", flt_addr, 32'h11fe_ffff);
        check("t1_flt_seg", flt_seg, 3);
        xact("t1_ds_ok", {32'h0, 32'h11fe_fff0}, 2'b01, {3'd0, 3'd3}, {3'd0, 3'd5},
             1'b0, 3'd0, 32'h0, 1'b0, 2'b00);

        // 2: saturation, exemption, invalid channel
        xact("t2_es_sat", {32'h0, 32'hffff_ffff}, 2'b01, {3'd0, 3'd0}, {3'd0, 3'd3},
             1'b0, 3'd0, 32'h0, 1'b0, 2'b01);
        xact("t2_ss_exempt", {32'h0, 32'hffff_ffff}, 2'b01, {3'd0, 3'd2}, {3'd0, 3'd3},
             1'b0, 3'd0, 32'h0, 1'b0, 2'b00);
        xact("t2_novld", {32'h0, 32'hffff_ffff}, 2'b00, {3'd0, 3'd0}, {3'd0, 3'd3},
             1'b0, 3'd0, 32'h0, 1'b0, 2'b00);
        check("t2_flt_held", flt_addr, 32'h11fe_ffff);

        // 3: limit write vs same-cycle access, reserved segment write
        xact("t3_old_lim", {32'h0000_2000, 32'h0}, 2'b10, {3'd1, 3'd0}, 6'd0,
             1'b1, 3'd1, 32'h0000_1000, 1'b0, 2'b00);
        xact("t3_new_lim", {32'h0000_2000, 32'h0}, 2'b10, {3'd1, 3'd0}, 6'd0,
             1'b0, 3'd0, 32'h0, 1'b0, 2'b10);
        xact("t3_wr_seg7", {32'h0, 32'h0000_0100}, 2'b01, {3'd0, 3'd0}, 6'd0,
             1'b1, 3'd7, 32'hffff_ffff, 1'b0, 2'b00);
        xact("t3_seg7", {32'h0, 32'h0}, 2'b01, {3'd0, 3'd7}, 6'd0,
             1'b0, 3'd0, 32'h0, 1'b0, 2'b01);
        xact("t3_both", {32'h0800_0000, 32'h0000_0100}, 2'b11, {3'd5, 3'd3}, 6'd0,
             1'b0, 3'd0, 32'h0, 1'b0, 2'b10);

        // 4: backpressure while streaming
        out_ready = 1'b0;
        k = 0;
        acc_stall = 0;
        d0 = n_deliv;
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(posedge clk); #1;
            if (c == 3) out_ready = 1'b1;
            addr = {32'h0400_0000, 32'h11fe_fff0 + 32'(k * 8)};
            addr_vld = {k[0], 1'b1};
            seg = {3'd0, 3'd3};
            size = {3'd0, 3'd5};
            in_valid = 1'b1;
            @(negedge clk);
            if (c == 2) check("t4_ready_drop", in_ready, 0);
            if (in_valid && in_ready) begin
                k++;
                if (c < 3) acc_stall++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t4_all_accepted", k, 6);
        check("t4_stall_accepts", acc_stall, 2);
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) @(negedge clk);
        check("t4_delivered", n_deliv - d0, 6);

        // 5: first-fault record and clear/capture collision
        @(posedge clk); #1 flt_clr = 1'b1;
        @(posedge clk); #1 flt_clr = 1'b0;
        @(negedge clk);
        check("t5_cleared", flt_valid, 0);
        xact("t5_f1", {32'h0400_0000, 32'h0000_0100}, 2'b11, {3'd0, 3'd3}, 6'd0,
             1'b0, 3'd0, 32'h0, 1'b0, 2'b10);
        xact("t5_f2", {32'h0, 32'h0500_0000}, 2'b01, {3'd0, 3'd4}, 6'd0,
             1'b0, 3'd0, 32'h0, 1'b0, 2'b01);
        check("t5_hold_addr", flt_addr, 32'h0400_0000);
        check("t5_hold_seg", flt_seg, 0);
        xact("t5_clr_new", {32'h0400_0000, 32'h0800_0000}, 2'b11, {3'd0, 3'd5}, 6'd0,
             1'b0, 3'd0, 32'h0, 1'b1, 2'b11);
        check("t5_new_valid", flt_valid, 1);
        check("t5_new_addr", flt_addr, 32'h0800_0000);
        check("t5_new_seg", flt_seg, 5);

        // 6: reset with two transactions in flight
        @(posedge clk); #1;
        addr = {32'h0, 32'hffff_ffff}; addr_vld = 2'b01; seg = 6'd0; size = {3'd0, 3'd3};
        in_valid = 1'b1;
        @(posedge clk); #1;
        addr = {32'h0, 32'h0600_0000};
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_out_valid", out_valid, 0);
        check("t6_flt_valid", flt_valid, 0);
        check("t6_any_exc", any_exc, 0);
        @(negedge clk);
        check("t6_no_pulse", out_valid, 0);
        xact("t6_cs_default", {32'h0, 32'h0000_2000}, 2'b01, {3'd0, 3'd1}, 6'd0,
             1'b0, 3'd0, 32'h0, 1'b0, 2'b00);
        check("t6_flt_after", flt_valid, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
